demux_8bits_4ch: RTL and testbench
==================================

# demux_8bits_4ch

Registered 1-to-4 byte demultiplexer. It accepts one 8-bit word per cycle on a valid/ready input port and routes it to one of four output channels (a, b, c, d), or to all four at once. Each channel holds its word in a one-entry buffer with its own valid/ready handshake. It sits downstream of a shared byte bus and fans data back out to four independent consumers.

## Interface
Parameters:
- WIDTH, 8, data width per channel.
- CNT_W, 16, width of each per-channel delivery counter (used only with the counter feature).

Ports:
- clk, input, 1, the single clock; all state updates on its rising edge.
- rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
- in_data, input, WIDTH, word to route.
- in_dest, input, 2, destination channel: 0=a, 1=b, 2=c, 3=d.
- in_bcast, input, 1, when 1, in_dest is ignored and the word goes to all four channels.
- in_valid, input, 1, in_data, in_dest and in_bcast are valid this cycle.
- in_ready, output, 1, the block accepts the word this cycle.
- out_data, output, 4*WIDTH, channel data, packed: a=[WIDTH-1:0], b next, c next, d at the top.
- out_valid, output, 4, per-channel valid, bit 0=a … bit 3=d.
- out_ready, input, 4, per-channel consumer ready.
- out_count, output, 4*CNT_W, per-channel delivered-word counters, packed like out_data. Present only when DEMUX_COUNT_EN is defined.

## Operation
- Each channel is a one-entry slot with two states, EMPTY and FULL. The slot state drives out_valid[i].
- A channel i can take a word when it is EMPTY, or when it is FULL and out_ready[i]=1 (pass-through refill in the same cycle).
- in_ready rules:
  - Unicast: in_ready equals "channel in_dest can take a word".
  - Broadcast: in_ready is the AND over all four channels of "can take a word".
  - in_ready is combinational from in_dest, in_bcast, slot state and out_ready. It does not depend on in_valid.
- Accept: an input word is accepted when in_valid and in_ready are both 1. The word is written into the target slot(s), which become FULL.
- Drain: when out_valid[i] and out_ready[i] are both 1, the word is consumed. The slot goes EMPTY unless it is refilled in the same cycle.
- Simultaneous drain and accept on the same channel: the slot stays FULL, holds the new word, and out_valid stays 1.
- out_data[i] holds its value while the slot is FULL and not consumed. Its value while EMPTY is don't-care, but the implementation keeps the last value.
- A broadcast is atomic. All four slots load together, or none do.
- Words stay in order per channel. There is no reordering across channels.

## Timing
- Latency: a word accepted in cycle N is presented at its output (out_valid high) in cycle N+1.
- Throughput: one word per cycle per channel when the consumer holds out_ready high.
- Reset (rst_n=0 at an edge): all slots go EMPTY, out_valid=4'b0000, out_data all zero, out_count all zero.
- During reset in_ready is 0. It becomes valid the cycle after rst_n returns to 1.
- Reset asserted mid-transfer: any words buffered in the slots are discarded. Nothing is delivered for them.
- Changing in_data or in_dest while in_valid=1 and in_ready=0 is legal. The block uses the values present at the accepting edge.

## Configuration
- DEMUX_COUNT_EN
  - Defined: each channel has a CNT_W-bit counter that increments on every drain handshake. The counter wraps from 2^CNT_W−1 to 0 with no flag. A broadcast counts once per channel as each channel drains. out_count is exported.
  - Undefined: the counters and the out_count port do not exist. All other behaviour is identical.

## Structure
- Shared package demux_pkg:
  - NUM_CH=4.
  - Channel index constants CH_A=0, CH_B=1, CH_C=2, CH_D=3.
  - Slot state encoding EMPTY=1'b0, FULL=1'b1.
- Sub-module demux_slot: the one-entry buffer with its valid/ready pair and the optional counter. It is instantiated four times.
- The top level holds only the destination decode, the broadcast AND, and the port packing.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with in_valid=1 → out_valid=0000, out_data=0, in_ready=0; with DEMUX_COUNT_EN, out_count=0.
- Unicast routing: with out_ready=1111, send 8'h11/dest 0, 8'h22/dest 1, 8'h33/dest 2, 8'h44/dest 3 on consecutive cycles → each word appears one cycle later on channels a, b, c, d in turn, with out_valid one-hot.
- Backpressure on one channel:
  - Set out_ready[2]=0 and send 8'hA5 then 8'h5A to dest 2 → the first is accepted; in_ready=0 for the second.
  - Meanwhile 8'h77 to dest 0 is accepted.
  - Raise out_ready[2] → 8'hA5 drains and 8'h5A is accepted in the same cycle (slot stays FULL).
- Broadcast blocked: fill channel d and hold out_ready[3]=0, then send 8'hC3 with in_bcast=1 → in_ready=0 and channels a–c are not loaded. After d drains, 8'hC3 appears on all four channels in the same cycle.
- Reset mid-stream: with all slots FULL, pulse rst_n low for 1 cycle → out_valid=0000 on the next edge and no buffered word is ever delivered.
- Counter wrap (DEMUX_COUNT_EN, CNT_W=4): drain 17 words on channel b → out_count for b=1; the other counters are unchanged.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 byte demultiplexer: channel count,
// channel indices, slot state encoding and the destination decode helper.
package demux_pkg;

   localparam int unsigned NUM_CH = 4;

   localparam int unsigned CH_A = 0;
   localparam int unsigned CH_B = 1;
   localparam int unsigned CH_C = 2;
   localparam int unsigned CH_D = 3;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_e;

   // One-hot target mask for a word: every channel on broadcast, else in_dest.
   function automatic logic [NUM_CH-1:0] dest_mask(input logic [1:0] dest,
                                                   input logic       bcast);
      logic [NUM_CH-1:0] m;
      m = '0;
      if (bcast) begin
         m = '1;
      end else begin
         case (dest)
            2'(CH_A): m[CH_A] = 1'b1;
            2'(CH_B): m[CH_B] = 1'b1;
            2'(CH_C): m[CH_C] = 1'b1;
            default:  m[CH_D] = 1'b1;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer with a valid/ready pair. A FULL slot that is being
// drained can be refilled in the same cycle. Optional delivery counter when
// DEMUX_COUNT_EN is defined.
module demux_slot
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = 8
`ifdef DEMUX_COUNT_EN
   ,parameter int unsigned CNT_W = 16
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             out_ready,
   output logic             can_take,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
`ifdef DEMUX_COUNT_EN
   ,output logic [CNT_W-1:0] out_count
`endif
);

   slot_state_e      state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             drain;
`ifdef DEMUX_COUNT_EN
   logic [CNT_W-1:0] count_q, count_d;
`endif

   assign drain     = (state_q == FULL) && out_ready;
   assign can_take  = (state_q == EMPTY) || out_ready;
   assign out_valid = (state_q == FULL);
   assign out_data  = data_q;
`ifdef DEMUX_COUNT_EN
   assign out_count = count_q;
`endif

   // Next slot state: drain empties, a load (possibly same cycle) refills.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      if (drain) begin
         state_d = EMPTY;
      end
      if (load) begin
         state_d = FULL;
         data_d  = load_data;
      end
`ifdef DEMUX_COUNT_EN
      count_d = count_q;
      if (drain) begin
         count_d = count_q + 1'b1;
      end
`endif
   end

   // Slot registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         data_q  <= '0;
`ifdef DEMUX_COUNT_EN
         count_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
`ifdef DEMUX_COUNT_EN
         count_q <= count_d;
`endif
      end
   end

endmodule

// File: rtl/demux_8bits_4ch.sv
// Registered 1-to-4 byte demultiplexer with per-channel one-entry buffers and
// an atomic broadcast mode. Define DEMUX_COUNT_EN to add per-channel
// delivered-word counters exported on out_count.
module demux_8bits_4ch
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [1:0]            in_dest,
   input  logic                  in_bcast,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [4*WIDTH-1:0]    out_data,
   output logic [3:0]            out_valid,
   input  logic [3:0]            out_ready
`ifdef DEMUX_COUNT_EN
   ,output logic [4*CNT_W-1:0]   out_count
`endif
);

   logic [NUM_CH-1:0] can_take;
   logic [NUM_CH-1:0] target;
   logic [NUM_CH-1:0] load;
   logic              accept;
   logic              run_q, run_d;
   logic              ready_raw;

   // Ready stays low through reset and for the first cycle after release.
   always_comb begin
      run_d = 1'b1;
   end

   // Ready qualifier register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q <= 1'b0;
      end else begin
         run_q <= run_d;
      end
   end

   // Destination decode and broadcast AND of per-channel readiness.
   always_comb begin
      target    = dest_mask(in_dest, in_bcast);
      ready_raw = &(can_take | ~target);
      in_ready  = ready_raw && run_q && rst_n;
      accept    = in_valid && in_ready;
      load      = accept ? target : '0;
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      demux_slot #(
         .WIDTH (WIDTH)
`ifdef DEMUX_COUNT_EN
         ,.CNT_W (CNT_W)
`endif
      ) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load[i]),
         .load_data (in_data),
         .out_ready (out_ready[i]),
         .can_take  (can_take[i]),
         .out_valid (out_valid[i]),
         .out_data  (out_data[i*WIDTH +: WIDTH])
`ifdef DEMUX_COUNT_EN
         ,.out_count (out_count[i*CNT_W +: CNT_W])
`endif
      );
   end

`ifndef DEMUX_COUNT_EN
   // Counter width only matters when the counters are built.
   if (CNT_W == 0) begin : g_no_cnt
   end
`endif

endmodule

// File: tb/tb_demux_8bits_4ch.sv
// Self-checking bench for demux_8bits_4ch: directed scenarios followed by
// random traffic, all compared against a queue-free behavioural model.
module tb_demux_8bits_4ch;

   localparam int W  = 8;
   localparam int CW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [W-1:0]    in_data;
   logic [1:0]      in_dest;
   logic            in_bcast;
   logic            in_valid;
   logic            in_ready;
   logic [4*W-1:0]  out_data;
   logic [3:0]      out_valid;
   logic [3:0]      out_ready;
`ifdef DEMUX_COUNT_EN
   logic [4*CW-1:0] out_count;
`endif

   always #5 clk = ~clk;

   demux_8bits_4ch #(
      .WIDTH (W),
      .CNT_W (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_dest   (in_dest),
      .in_bcast  (in_bcast),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef DEMUX_COUNT_EN
      ,.out_count (out_count)
`endif
   );

   int vectors    = 0;
   int miscompares = 0;

   // Behavioural model: per channel, is a word waiting, which word, and how
   // many words have been handed to the consumer.
   bit          m_full [4];
   logic [7:0]  m_data [4];
   int unsigned m_cnt  [4];
   bit          m_run = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit exp_ready();
      bit r;
      if (!rst_n || !m_run) return 1'b0;
      if (in_bcast) begin
         r = 1'b1;
         for (int i = 0; i < 4; i++) r &= (!m_full[i] || out_ready[i]);
         return r;
      end
      return !m_full[in_dest] || out_ready[in_dest];
   endfunction

   task automatic drive(input bit v, input logic [7:0] d, input logic [1:0] dst, input bit bc);
      in_valid = v;
      in_data  = d;
      in_dest  = dst;
      in_bcast = bc;
   endtask

   // One clock: check ready before the edge, advance model, check outputs after.
   task automatic cycle();
      bit          er;
      logic [3:0]  ev;
      logic [31:0] ed;
      logic [15:0] ec;
      #1;
      er = exp_ready();
      chk("in_ready", in_ready, er);
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            m_full[i] = 1'b0;
            m_data[i] = 8'h00;
            m_cnt[i]  = 0;
         end
         m_run = 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (m_full[i] && out_ready[i]) begin
               m_full[i] = 1'b0;
               m_cnt[i]++;
            end
         end
         if (in_valid && er) begin
            for (int i = 0; i < 4; i++) begin
               if (in_bcast || in_dest == 2'(i)) begin
                  m_full[i] = 1'b1;
                  m_data[i] = in_data;
               end
            end
         end
         m_run = 1'b1;
      end
      #1;
      for (int i = 0; i < 4; i++) begin
         ev[i]          = m_full[i];
         ed[i*8 +: 8]   = m_data[i];
         ec[i*4 +: 4]   = 4'(m_cnt[i] % 16);
      end
      chk("out_valid", out_valid, ev);
      chk("out_data", out_data, ed);
`ifdef DEMUX_COUNT_EN
      chk("out_count", out_count, ec);
`else
      if (ec === 16'hxxxx) chk("count_model", ec, 16'h0);
`endif
   endtask

   initial begin
      // Reset with in_valid asserted.
      rst_n = 1'b0;
      out_ready = 4'b1111;
      drive(1'b1, 8'hEE, 2'd1, 1'b0);
      cycle();
      cycle();
      chk("reset_valid", out_valid, 4'b0000);
      chk("reset_data", out_data, 32'h0);
      rst_n = 1'b1;
      drive(1'b0, 8'h00, 2'd0, 1'b0);
      cycle();

      // Unicast routing, one word per cycle.
      drive(1'b1, 8'h11, 2'd0, 1'b0); cycle();
      chk("uni_a", out_valid, 4'b0001);
      drive(1'b1, 8'h22, 2'd1, 1'b0); cycle();
      chk("uni_b", out_valid, 4'b0010);
      drive(1'b1, 8'h33, 2'd2, 1'b0); cycle();
      chk("uni_c", out_valid, 4'b0100);
      drive(1'b1, 8'h44, 2'd3, 1'b0); cycle();
      chk("uni_d", {out_valid, out_data[31:24]}, {4'b1000, 8'h44});
      drive(1'b0, 8'h00, 2'd0, 1'b0); cycle();

      // Backpressure on channel c.
      out_ready = 4'b1011;
      drive(1'b1, 8'hA5, 2'd2, 1'b0); cycle();
      drive(1'b1, 8'h5A, 2'd2, 1'b0); #1;
      chk("bp_blocked", in_ready, 1'b0);
      cycle();
      drive(1'b1, 8'h77, 2'd0, 1'b0); cycle();
      chk("bp_c_held", out_data[23:16], 8'hA5);
      out_ready = 4'b1111;
      drive(1'b1, 8'h5A, 2'd2, 1'b0); #1;
      chk("bp_refill_ready", in_ready, 1'b1);
      cycle();
      chk("bp_refill", {out_valid[2], out_data[23:16]}, {1'b1, 8'h5A});
      drive(1'b0, 8'h00, 2'd0, 1'b0); cycle();

      // Broadcast blocked by a full channel d.
      out_ready = 4'b0111;
      drive(1'b1, 8'hDD, 2'd3, 1'b0); cycle();
      drive(1'b1, 8'hC3, 2'd0, 1'b1); cycle();
      chk("bc_blocked", out_valid, 4'b1000);
      cycle();
      out_ready = 4'b1111;
      cycle();
      chk("bc_all", {out_valid, out_data}, {4'b1111, 32'hC3C3C3C3});
      drive(1'b0, 8'h00, 2'd0, 1'b0); cycle();

      // Reset mid-stream with all slots full.
      out_ready = 4'b0000;
      drive(1'b1, 8'h99, 2'd0, 1'b1); cycle();
      drive(1'b0, 8'h00, 2'd0, 1'b0);
      rst_n = 1'b0; cycle();
      chk("mid_reset", out_valid, 4'b0000);
      rst_n = 1'b1;
      out_ready = 4'b1111;
      cycle();
      cycle();
      chk("mid_reset_nodeliver", out_valid, 4'b0000);

`ifdef DEMUX_COUNT_EN
      // 17 drains on channel b wrap a 4-bit counter to 1.
      for (int k = 0; k < 17; k++) begin
         drive(1'b1, 8'(k), 2'd1, 1'b0); cycle();
      end
      drive(1'b0, 8'h00, 2'd0, 1'b0); cycle();
      chk("cnt_wrap_b", out_count[7:4], 4'd1);
      chk("cnt_others", {out_count[15:8], out_count[3:0]}, 12'h000);
`endif

      // Random traffic with occasional reset.
      for (int k = 0; k < 400; k++) begin
         drive(1'($urandom), 8'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0));
         out_ready = 4'($urandom);
         rst_n = ($urandom_range(0, 49) != 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
